pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage ARM pipeline.
- Produces freeze for PC and the IF/ID register, flush for IF/ID and ID/EX, a bubble into ID/EX, and a global memory stall.
- Inputs: ID-stage source registers, EX/MEM destinations, EX-stage branch resolution, and a multi-cycle data-memory ready handshake.
- Sits beside the stage registers in topLevel and replaces the ad-hoc freeze/flush wiring.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Brief   : Shared types and defaults for the pipeline hazard controller.
// Revision: 1.0
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_hazard_detect
// Brief   : Combinational RAW match of ID sources against EX/MEM destinations.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter bit          FWD_EN     = 1'b0
) (
    input  logic [REG_ADDR_W-1:0] src1_id,
    input  logic [REG_ADDR_W-1:0] src2_id,
    input  logic                  use_src1_id,
    input  logic                  use_src2_id,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  hazard
);

    logic exe_hit;
    logic mem_hit;
    logic exe_qual;

    always_comb begin
        exe_hit = exe_wb_en & ((use_src1_id & (src1_id == exe_dest)) |
                               (use_src2_id & (src2_id == exe_dest)));
        mem_hit = mem_wb_en & ((use_src1_id & (src1_id == mem_dest)) |
                               (use_src2_id & (src2_id == mem_dest)));
        // With forwarding, only a load in EX cannot be bypassed in time.
        exe_qual = FWD_EN ? (exe_hit & exe_mem_read) : exe_hit;
        hazard   = exe_qual | (mem_hit & ~FWD_EN);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Pipeline sequencer: freeze/bubble/flush priority, memory-wait FSM
//           with timeout abort, and saturating stall counter.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter bit          FWD_EN      = 1'b0,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1_id,
    input  logic [REG_ADDR_W-1:0] src2_id,
    input  logic                  use_src1_id,
    input  logic                  use_src2_id,
    input  logic                  exe_wb_en,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_mem_read,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  branch_taken_exe,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  freeze,
    output logic                  bubble_id,
    output logic                  flush,
    output logic                  mem_stall,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int unsigned          WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               stall_raw;
    logic               hazard;

    pipeline_hazard_ctrl_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_hazard_detect (
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .use_src1_id  (use_src1_id),
        .use_src2_id  (use_src2_id),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .hazard       (hazard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_raw  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    stall_raw  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    stall_raw = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            ST_TIMEOUT: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    // A taken branch squashes the ID instruction, so its hazard is moot.
    always_comb begin
        freeze    = 1'b0;
        bubble_id = 1'b0;
        flush     = 1'b0;
        mem_stall = 1'b0;
        if (rst) begin
            if (stall_raw) begin
                mem_stall = 1'b1;
                freeze    = 1'b1;
            end else if (branch_taken_exe) begin
                flush = 1'b1;
            end else if (hazard) begin
                freeze    = 1'b1;
                bubble_id = 1'b1;
            end
        end
    end

    always_comb begin
        timeout_d   = timeout_q | (state_d == ST_TIMEOUT);
        stall_cnt_d = stall_cnt_q;
        if ((freeze || mem_stall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed plus randomized bench; two configurations checked
//           against a cycle-level behavioural model.
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] src1_id = '0, src2_id = '0, exe_dest = '0, mem_dest = '0;
    logic       use_src1_id = 0, use_src2_id = 0, exe_wb_en = 0, exe_mem_read = 0;
    logic       mem_wb_en = 0, branch_taken_exe = 0, mem_req = 0, mem_ready = 0;

    logic        fr[2], bub[2], fl[2], ms[2], to[2];
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Configuration table: A = no forwarding, B = forwarding, short timeout, tiny counter.
    int cfg_to[2]   = '{4, 2};
    int cfg_fwd[2]  = '{0, 1};
    int cfg_cmax[2] = '{65535, 15};

    // Model state: stalled cycles of the current access, abort cycle pending, flag, count.
    bit m_waiting[2];
    int m_waited[2];
    bit m_abort[2];
    bit m_flag[2];
    int m_cnt[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(4), .FWD_EN(1'b0), .MEM_TIMEOUT(4), .CNT_W(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .src1_id(src1_id), .src2_id(src2_id),
        .use_src1_id(use_src1_id), .use_src2_id(use_src2_id),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .branch_taken_exe(branch_taken_exe), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze(fr[0]), .bubble_id(bub[0]), .flush(fl[0]), .mem_stall(ms[0]),
        .mem_timeout(to[0]), .stall_count(sc_a)
    );

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(4), .FWD_EN(1'b1), .MEM_TIMEOUT(2), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .src1_id(src1_id), .src2_id(src2_id),
        .use_src1_id(use_src1_id), .use_src2_id(use_src2_id),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .branch_taken_exe(branch_taken_exe), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze(fr[1]), .bubble_id(bub[1]), .flush(fl[1]), .mem_stall(ms[1]),
        .mem_timeout(to[1]), .stall_count(sc_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit model_hazard(int k);
        logic [3:0] s[2];
        bit         u[2];
        bit         h;
        s = '{src1_id, src2_id};
        u = '{use_src1_id, use_src2_id};
        h = 0;
        for (int j = 0; j < 2; j++) begin
            if (u[j]) begin
                if (exe_wb_en && s[j] == exe_dest && (cfg_fwd[k] == 0 || exe_mem_read)) h = 1;
                if (cfg_fwd[k] == 0 && mem_wb_en && s[j] == mem_dest) h = 1;
            end
        end
        return h;
    endfunction

    // Returns {mem_stall, freeze, bubble_id, flush}.
    function automatic logic [3:0] model_comb(int k);
        bit s, h;
        if (!rst) return 4'b0000;
        if (m_abort[k])        s = 0;
        else if (m_waiting[k]) s = !mem_ready;
        else                   s = mem_req && !mem_ready;
        h = model_hazard(k);
        if (s)                     return 4'b1100;
        else if (branch_taken_exe) return 4'b0001;
        else if (h)                return 4'b0110;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_waiting[k] = 0; m_waited[k] = 0; m_abort[k] = 0; m_flag[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_advance();
        logic [3:0] e;
        for (int k = 0; k < 2; k++) begin
            e = model_comb(k);
            if ((e[3] || e[2]) && m_cnt[k] < cfg_cmax[k]) m_cnt[k]++;
            if (m_abort[k]) begin
                m_abort[k] = 0; m_waiting[k] = 0; m_waited[k] = 0;
            end else if (e[3]) begin
                m_waited[k] = m_waiting[k] ? m_waited[k] + 1 : 1;
                if (m_waited[k] == cfg_to[k] + 1) begin
                    m_abort[k] = 1; m_flag[k] = 1; m_waiting[k] = 0;
                end else begin
                    m_waiting[k] = 1;
                end
            end else begin
                m_waiting[k] = 0; m_waited[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e;
        string      p;
        for (int k = 0; k < 2; k++) begin
            e = model_comb(k);
            p = (k == 0) ? "a" : "b";
            check_eq({p, "_mem_stall"}, ms[k],  e[3]);
            check_eq({p, "_freeze"},    fr[k],  e[2]);
            check_eq({p, "_bubble_id"}, bub[k], e[1]);
            check_eq({p, "_flush"},     fl[k],  e[0]);
            check_eq({p, "_timeout"},   to[k],  m_flag[k]);
        end
        check_eq("a_stall_count", sc_a, m_cnt[0]);
        check_eq("b_stall_count", sc_b, m_cnt[1]);
    endtask

    // Called with inputs already driven just after a falling edge.
    task automatic step();
        #1;
        check_all();
        if (rst) model_advance();
        else     model_reset();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {src1_id, src2_id, exe_dest, mem_dest} = '0;
        {use_src1_id, use_src2_id, exe_wb_en, exe_mem_read} = '0;
        {mem_wb_en, branch_taken_exe, mem_req} = '0;
        mem_ready = 1'b1;
    endtask

    task automatic idle(int n);
        clear_inputs();
        repeat (n) step();
    endtask

    initial begin
        model_reset();
        clear_inputs();
        @(negedge clk);
        step();
        step();
        rst = 1'b1;
        step();

        // Load-use on src1 (no forwarding in A, non-load in EX for B).
        use_src1_id = 1; src1_id = 4'd3; exe_wb_en = 1; exe_dest = 4'd3;
        #1;
        check_eq("a_loaduse_freeze", fr[0], 1'b1);
        check_eq("a_loaduse_bubble", bub[0], 1'b1);
        check_eq("b_loaduse_fwd_freeze", fr[1], 1'b0);
        #1;
        step();
        check_eq("a_loaduse_count", sc_a, 16'd1);

        // Taken branch outranks a matching src2.
        clear_inputs();
        branch_taken_exe = 1; use_src2_id = 1; src2_id = 4'd5; exe_wb_en = 1; exe_dest = 4'd5;
        step();

        // Three not-ready cycles then ready.
        clear_inputs();
        mem_req = 1; mem_ready = 0;
        repeat (3) step();
        mem_ready = 1;
        step();
        idle(2);

        // Unanswered access: A times out after 5 stalled cycles.
        mem_req = 1; mem_ready = 0;
        repeat (6) step();
        check_eq("a_timeout_sticky", to[0], 1'b1);
        idle(3);
        check_eq("a_timeout_held", to[0], 1'b1);

        // Branch held visible through a 2-cycle wait.
        mem_req = 1; mem_ready = 0; branch_taken_exe = 1;
        repeat (2) step();
        mem_ready = 1;
        step();
        idle(2);

        // Async reset while waiting.
        mem_req = 1; mem_ready = 0;
        repeat (2) step();
        #2 rst = 1'b0;
        #1;
        check_eq("a_rst_mem_stall", ms[0], 1'b0);
        check_eq("a_rst_freeze", fr[0], 1'b0);
        check_eq("a_rst_timeout", to[0], 1'b0);
        check_eq("a_rst_count", sc_a, 16'd0);
        check_eq("b_rst_timeout", to[1], 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Forwarding qualification.
        use_src1_id = 1; src1_id = 4'd7; mem_wb_en = 1; mem_dest = 4'd7;
        step();
        mem_wb_en = 0; exe_wb_en = 1; exe_dest = 4'd7;
        step();
        exe_mem_read = 1;
        step();
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            src1_id          = 4'($urandom_range(0, 3));
            src2_id          = 4'($urandom_range(0, 3));
            exe_dest         = 4'($urandom_range(0, 3));
            mem_dest         = 4'($urandom_range(0, 3));
            use_src1_id      = 1'($urandom);
            use_src2_id      = 1'($urandom);
            exe_wb_en        = 1'($urandom);
            exe_mem_read     = 1'($urandom);
            mem_wb_en        = 1'($urandom);
            branch_taken_exe = ($urandom_range(0, 3) == 0);
            mem_req          = ($urandom_range(0, 2) == 0);
            mem_ready        = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
